// File: rtl/pulse_stretcher.sv
// Pulse stretcher: each rising edge on `in` queues one event. Every event
// produces one ON period of 2**WIDTH cycles followed by one OFF gap of the
// same length. Events that arrive while a pulse is in progress are counted
// in a saturating pending counter. A sticky flag records any event dropped
// because that counter was already full.
module pulse_stretcher #(
    parameter int WIDTH      = 16,
    parameter int PEND_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in,
    input  logic                  clr,
    output logic                  out,
    output logic                  busy,
    output logic [PEND_WIDTH-1:0] pending,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]      CNT_MAX  = '1;
    localparam logic [WIDTH-1:0]      CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
    localparam logic [PEND_WIDTH-1:0] PEND_ONE = {{(PEND_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_reg, state_next;
    logic [WIDTH-1:0]        cnt_reg, cnt_next;
    logic                    in_d_reg;
    logic [PEND_WIDTH-1:0]   pending_reg, pending_next;
    logic                    overflow_reg, overflow_next;
    logic                    out_reg;

    logic                    evt;
    logic                    cnt_done;
    logic                    restart;

    // A level held high counts as a single event.
    assign evt      = in & ~in_d_reg;
    assign cnt_done = (cnt_reg == CNT_MAX);
    // End of an OFF gap with more work queued: go straight back to ON.
    // A clear in the same cycle wins, so the train stops and the block idles.
    assign restart  = (state_reg == OFF) && cnt_done && !clr &&
                      ((pending_reg != '0) || evt);

    // Next-state and period counter: the counter restarts on every state change.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_ONE;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (evt) begin
                    state_next = ON;
                end
            end
            ON: begin
                if (cnt_done) begin
                    state_next = OFF;
                    cnt_next   = '0;
                end
            end
            OFF: begin
                if (cnt_done) begin
                    state_next = restart ? ON : IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pending/overflow bookkeeping: events are queued only while a pulse runs.
    always_comb begin
        pending_next  = pending_reg;
        overflow_next = overflow_reg;
        if (clr) begin
            pending_next  = '0;
            overflow_next = 1'b0;
        end else if (state_reg != IDLE) begin
            if (restart) begin
                // One queued event is consumed; a same-cycle event replaces it.
                // With nothing queued, the same-cycle event is the one consumed.
                if ((pending_reg != '0) && !evt) begin
                    pending_next = pending_reg - PEND_ONE;
                end
            end else if (evt) begin
                if (pending_reg == PEND_MAX) begin
                    overflow_next = 1'b1;
                end else begin
                    pending_next = pending_reg + PEND_ONE;
                end
            end
        end
    end

    // State, counters, flags and the registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            in_d_reg     <= 1'b0;
            pending_reg  <= '0;
            overflow_reg <= 1'b0;
            out_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            in_d_reg     <= in;
            pending_reg  <= pending_next;
            overflow_reg <= overflow_next;
            out_reg      <= (state_next == ON);
        end
    end

    assign out      = out_reg;
    assign busy     = (state_reg != IDLE);
    assign pending  = pending_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher (WIDTH=3, PEND_WIDTH=2). A behavioural model,
// based on elapsed time since the current pulse started, pushes the expected
// outputs after every clock edge. A monitor pops and compares them on the
// falling edge.
module tb_pulse_stretcher;

    localparam int W    = 3;
    localparam int PW   = 2;
    localparam int P    = 1 << W;
    localparam int QMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_s = 1'b0;
    logic          clr_s = 1'b0;
    logic          out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    typedef struct packed {
        logic          out;
        logic          busy;
        logic [PW-1:0] pend;
        logic          ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   pops = 0;

    // Reference model state.
    bit   m_active = 0;
    int   m_elapsed = 0;
    int   m_q = 0;
    bit   m_ovf = 0;
    bit   m_prev = 0;

    pulse_stretcher #(.WIDTH(W), .PEND_WIDTH(PW)) dut (
        .clk(clk), .rst_n(rst_n), .in(in_s), .clr(clr_s),
        .out(out), .busy(busy), .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit i, input bit c);
        bit ev;
        bit consumed;
        ev = i && !m_prev;
        m_prev = i;
        consumed = 0;
        if (!m_active) begin
            if (ev) begin
                m_active = 1;
                m_elapsed = 0;
                consumed = 1;
            end
        end else begin
            m_elapsed++;
            if (m_elapsed == 2 * P) begin
                if (!c && (m_q > 0 || ev)) begin
                    m_elapsed = 0;
                    if (m_q > 0) m_q--;
                    else consumed = 1;
                end else begin
                    m_active = 0;
                end
            end
            if (ev && !consumed && !c) begin
                if (m_q == QMAX) m_ovf = 1;
                else m_q++;
            end
        end
        if (c) begin
            m_q = 0;
            m_ovf = 0;
        end
    endtask

    // Apply inputs, let one edge go by, record what the model expects.
    task automatic tick(input bit i, input bit c);
        exp_t e;
        in_s = i;
        clr_s = c;
        @(posedge clk);
        model_step(i, c);
        e.out  = m_active && (m_elapsed < P);
        e.busy = m_active;
        e.pend = PW'(m_q);
        e.ovf  = m_ovf;
        sb.push_back(e);
        #1;
    endtask

    task automatic idle_ticks(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0);
    endtask

    task automatic check_reset_now(input string tag);
        checks++;
        if (out !== 1'b0 || busy !== 1'b0 || pending !== '0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL %s: got out=%b busy=%b pending=%0d overflow=%b, required all 0",
                     tag, out, busy, pending, overflow);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            pops++;
            checks++;
            if (out !== e.out) begin
                failures++;
                $display("FAIL out @%0t: got %b, required %b", $time, out, e.out);
            end
            checks++;
            if (busy !== e.busy) begin
                failures++;
                $display("FAIL busy @%0t: got %b, required %b", $time, busy, e.busy);
            end
            checks++;
            if (pending !== e.pend) begin
                failures++;
                $display("FAIL pending @%0t: got %0d, required %0d", $time, pending, e.pend);
            end
            checks++;
            if (overflow !== e.ovf) begin
                failures++;
                $display("FAIL overflow @%0t: got %b, required %b", $time, overflow, e.ovf);
            end
        end
    end

    initial begin
        #12;
        check_reset_now("reset_state");
        rst_n = 1'b1;

        // 1: held level is a single event
        $display("scenario 1: held level");
        for (int k = 0; k < 20; k++) tick(1'b1, 1'b0);
        idle_ticks(10);

        // 2: three events queued during ON
        $display("scenario 2: three queued events");
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin tick(1'b1, 1'b0); tick(1'b0, 1'b0); end
        idle_ticks(70);

        // 3: saturation and sticky overflow, then clr
        $display("scenario 3: saturation");
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin tick(1'b1, 1'b0); tick(1'b0, 1'b0); end
        idle_ticks(70);
        tick(1'b0, 1'b1);
        idle_ticks(3);

        // 4a: event on the last OFF cycle with nothing pending
        $display("scenario 4: event on last OFF cycle");
        tick(1'b1, 1'b0);
        idle_ticks(15);
        tick(1'b1, 1'b0);
        idle_ticks(20);
        // 4b: same with pending saturated
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin tick(1'b1, 1'b0); tick(1'b0, 1'b0); end
        idle_ticks(8);
        tick(1'b1, 1'b0);
        idle_ticks(80);

        // 5: clr with an event during ON, pending=2
        $display("scenario 5: clr during ON");
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin tick(1'b1, 1'b0); tick(1'b0, 1'b0); end
        tick(1'b1, 1'b1);
        idle_ticks(20);

        // 6: asynchronous reset mid-pulse with pending=2
        $display("scenario 6: reset mid-pulse");
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        in_s = 1'b0;
        #1;
        check_reset_now("async_reset");
        m_active = 0; m_elapsed = 0; m_q = 0; m_ovf = 0; m_prev = 0;
        idle_ticks(3);
        rst_n = 1'b1;
        idle_ticks(12);

        // Random traffic
        $display("random phase");
        for (int k = 0; k < 3000; k++) begin
            bit ri;
            bit rc;
            ri = ($urandom_range(0, 3) == 0) ? ~in_s : in_s;
            rc = ($urandom_range(0, 79) == 0);
            tick(ri, rc);
        end
        idle_ticks(5);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0 || pops < 3000) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left, %0d popped, required 0 left, >=3000 popped",
                     sb.size(), pops);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
